// File: rtl/mult_shift_add.sv
// Sequential shift-and-add unsigned multiplier with start/busy/done handshake.
// The per-iteration partial-product add is a WIDTH-bit ripple chain built
// from halfadder cells: one at bit 0, a halfadder pair plus OR on higher bits.

// Single-bit half adder cell.
module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module mult_shift_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     add_s;
    logic [WIDTH-1:0]     add_c;
    logic                 load;
    logic                 last;

    wire [WIDTH-1:0] acc_hi = acc[2*WIDTH-1:WIDTH];

    // Ripple chain: acc upper half + mcand, carry out kept in add_c[WIDTH-1].
    halfadder u_ha0 (
        .x (acc_hi[0]),
        .y (mcand[0]),
        .s (add_s[0]),
        .c (add_c[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
        logic s1, c1, c2;
        halfadder u_ha_a (
            .x (acc_hi[i]),
            .y (mcand[i]),
            .s (s1),
            .c (c1)
        );
        halfadder u_ha_b (
            .x (s1),
            .y (add_c[i-1]),
            .s (add_s[i]),
            .c (c2)
        );
        assign add_c[i] = c1 | c2;
    end

    // Partial-product select and shifted accumulator value for this iteration.
    always_comb begin
        sum     = acc[0] ? {add_c[WIDTH-1], add_s} : {1'b0, acc_hi};
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        last      = (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath registers and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                mcand <= a;
                acc   <= {{WIDTH{1'b0}}, b};
                cnt   <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                // Capture the final shift directly so p is valid alongside done.
                if (last) p <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed-vector bench for mult_shift_add (WIDTH=8).
module tb_mult_shift_add;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    int vectors;
    int miscompares;

    mult_shift_add #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one accepted edge.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting ticks and busy cycles on the way.
    task automatic wait_done(input string tag, output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, (cyc < 40) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Full single product with an idle gap afterwards.
    task automatic run_mul(input string tag, input logic [WIDTH-1:0] av,
                           input logic [WIDTH-1:0] bv, input logic [2*WIDTH-1:0] exp);
        int cyc, bcyc;
        issue(av, bv);
        wait_done(tag, cyc, bcyc);
        check({tag, "_latency"}, cyc, WIDTH);
        check({tag, "_busycyc"}, bcyc, WIDTH);
        check({tag, "_p"}, p, exp);
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_p_hold"}, p, exp);
    endtask

    initial begin
        int cyc, bcyc, pulses;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_p", p, 0);

        // 3*5, also p must stay 0 during the first RUN after reset.
        issue(8'd3, 8'd5);
        check("run_busy", busy, 1);
        check("run_p_prev", p, 0);
        wait_done("m3x5", cyc, bcyc);
        check("m3x5_latency", cyc, WIDTH);
        check("m3x5_busycyc", bcyc, WIDTH);
        check("m3x5_p", p, 15);
        tick();
        check("m3x5_done_drop", done, 0);
        check("m3x5_idle_busy", busy, 0);

        run_mul("m255x255", 8'd255, 8'd255, 16'hFE01);
        run_mul("m0x200", 8'd0, 8'd200, 16'd0);
        run_mul("m200x0", 8'd200, 8'd0, 16'd0);
        run_mul("m128x2", 8'd128, 8'd2, 16'd256);

        // Back-to-back: start held during DONE launches the next product.
        issue(8'd7, 8'd9);
        wait_done("b2b1", cyc, bcyc);
        check("b2b1_p", p, 63);
        a     = 8'd12;
        b     = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_no_bubble", busy, 1);
        check("b2b_p_hold", p, 63);
        wait_done("b2b2", cyc, bcyc);
        check("b2b2_spacing", cyc + 1, WIDTH + 1);
        check("b2b2_p", p, 132);
        tick();

        // Start and operand changes during RUN are ignored.
        issue(8'd6, 8'd7);
        tick();
        tick();
        a     = 8'd99;
        b     = 8'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                check("ign_p", p, 42);
                check("ign_latency", i + 3, WIDTH);
            end
            check("ign_excl", busy & done, 0);
            tick();
        end
        check("ign_pulses", pulses, 1);

        // Reset mid-RUN at iteration 4 (start also high: reset wins).
        issue(8'd10, 8'd10);
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before", busy, 1);
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_p", p, 0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        check("rst_mid_quiet", pulses, 0);

        run_mul("m10x10", 8'd10, 8'd10, 16'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
